// File: rtl/multdiv_unit_if.sv
// Operand/control/result bundle between the execute stage and the multiply/divide unit.
//   data_operandA   : multiplicand / dividend, two's complement
//   data_operandB   : multiplier / divisor, two's complement
//   ctrl_MULT       : start-multiply pulse
//   ctrl_DIV        : start-divide pulse
//   data_result     : low WIDTH bits of product, or quotient
//   data_exception  : overflow / divide-by-zero flag for the last operation
//   data_resultRDY  : one-cycle pulse, result and exception valid
// master drives operands and starts; slave (the unit) drives the result side.
interface multdiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit.
// Multiply is radix-2 shift-add, divide is restoring division, both on operand magnitudes,
// followed by a sign-correction cycle and an output-load cycle. Latency is fixed: a start
// sampled at edge 0 gives data_resultRDY high after edge WIDTH+2.
// Ports:
//   clock       : system clock, all state on rising edge
//   ctrl_reset  : asynchronous active-low reset
//   bus         : multdiv_unit_if slave (operands, start pulses, result, exception, ready)
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clock,
  input logic           ctrl_reset,
  multdiv_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               fix_phase_q;  // 0: sign-correct, 1: load outputs
  logic               op_div_q;
  logic               neg_q;        // operand signs differ
  logic               div_zero_q;
  logic               div_ovf_q;
  // MUL: shifting multiplicand. DIV: low WIDTH bits hold dividend, quotient shifts in.
  logic [2*WIDTH-1:0] mcand_q;
  // MUL: shifting multiplier magnitude. DIV: divisor magnitude.
  logic [WIDTH:0]     mplier_q;
  // MUL: product accumulator. DIV: low bits hold the partial remainder.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   fix_result_q;
  logic               fix_exc_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;

  logic               start_mul;
  logic               start_div;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     b_ext;
  logic [WIDTH:0]     a_mag;
  logic [WIDTH:0]     b_mag;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic               mul_exc;

  assign start_mul = bus.ctrl_MULT & ~bus.ctrl_DIV;
  assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;

  always_comb begin
    // Sign-extend by one bit so the magnitude of the most negative value is representable.
    a_ext = {bus.data_operandA[WIDTH-1], bus.data_operandA};
    b_ext = {bus.data_operandB[WIDTH-1], bus.data_operandB};
    a_mag = bus.data_operandA[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
    b_mag = bus.data_operandB[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;
  end

  always_comb begin
    mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    div_shift    = {acc_q[WIDTH-1:0], mcand_q[WIDTH-1]};
    div_ge       = (div_shift >= mplier_q);
    div_diff     = div_shift - mplier_q;
    prod_signed  = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_signed  = neg_q ? (~mcand_q[WIDTH-1:0] + 1'b1) : mcand_q[WIDTH-1:0];
    // Overflow when the full product does not survive truncation to WIDTH bits.
    mul_exc      = (prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}});
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fix_phase_q  <= 1'b0;
      op_div_q     <= 1'b0;
      neg_q        <= 1'b0;
      div_zero_q   <= 1'b0;
      div_ovf_q    <= 1'b0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      fix_result_q <= '0;
      fix_exc_q    <= 1'b0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start_mul || start_div) begin
        // A start always wins, aborting any operation in flight.
        state_q     <= start_div ? StDiv : StMul;
        op_div_q    <= start_div;
        cnt_q       <= '0;
        fix_phase_q <= 1'b0;
        neg_q       <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        div_zero_q  <= (bus.data_operandB == '0);
        div_ovf_q   <= (bus.data_operandA == MinVal) && (bus.data_operandB == '1);
        mcand_q     <= (2*WIDTH)'(a_mag);
        mplier_q    <= b_mag;
        acc_q       <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StMul: begin
            acc_q    <= mul_acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q     <= StFix;
              fix_phase_q <= 1'b0;
            end
          end
          StDiv: begin
            acc_q                <= (2*WIDTH)'(div_ge ? div_diff : div_shift);
            mcand_q[WIDTH-1:0]   <= {mcand_q[WIDTH-2:0], div_ge};
            cnt_q                <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q     <= StFix;
              fix_phase_q <= 1'b0;
            end
          end
          StFix: begin
            if (!fix_phase_q) begin
              fix_phase_q <= 1'b1;
              if (op_div_q) begin
                // Most-negative / -1 yields magnitude 2^(WIDTH-1) unsigned, already the
                // wrapped result; only the flag needs raising.
                fix_result_q <= div_zero_q ? '0 : quot_signed;
                fix_exc_q    <= div_zero_q | div_ovf_q;
              end else begin
                fix_result_q <= prod_signed[WIDTH-1:0];
                fix_exc_q    <= mul_exc;
              end
            end else begin
              result_q    <= fix_result_q;
              exc_q       <= fix_exc_q;
              rdy_q       <= 1'b1;
              fix_phase_q <= 1'b0;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: a behavioural model (64-bit integer arithmetic plus a pending-result
// deadline) predicts result/exception/ready every cycle; directed cases pin literal values.
module tb_multdiv_unit;

  localparam int unsigned W   = 32;
  localparam int          Lat = 34;

  logic clock      = 1'b0;
  logic ctrl_reset = 1'b1;

  multdiv_unit_if #(.WIDTH(W)) bus ();

  multdiv_unit #(.WIDTH(W)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic from the operation's definition.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input bit is_div,
                                 output logic [31:0] r, output bit e);
    longint sa;
    longint sb;
    longint p;
    logic [31:0] lo;
    sa = $signed(a);
    sb = $signed(b);
    if (!is_div) begin
      p  = sa * sb;
      lo = p[31:0];
      r  = lo;
      e  = (p != longint'($signed(lo)));
    end else if (b == 32'h0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  // Model state: the most recent start sets a deadline; a newer start or reset cancels it.
  int          edge_n    = 0;
  bit          pend      = 1'b0;
  int          pend_edge = 0;
  logic [31:0] pend_res  = '0;
  bit          pend_exc  = 1'b0;
  logic [31:0] exp_res   = '0;
  bit          exp_exc   = 1'b0;
  bit          exp_rdy   = 1'b0;

  always @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      pend    = 1'b0;
      exp_res = '0;
      exp_exc = 1'b0;
      exp_rdy = 1'b0;
    end else begin
      edge_n++;
      exp_rdy = 1'b0;
      if (bus.ctrl_MULT ^ bus.ctrl_DIV) begin
        pend      = 1'b1;
        pend_edge = edge_n + Lat;
        ref_op(bus.data_operandA, bus.data_operandB, bus.ctrl_DIV, pend_res, pend_exc);
      end else if (pend && edge_n == pend_edge) begin
        pend    = 1'b0;
        exp_rdy = 1'b1;
        exp_res = pend_res;
        exp_exc = pend_exc;
      end
    end
  end

  always @(negedge clock) begin
    check("cyc_rdy", 32'(bus.data_resultRDY), 32'(exp_rdy));
    check("cyc_result", bus.data_result, exp_res);
    check("cyc_exc", 32'(bus.data_exception), 32'(exp_exc));
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit is_div);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = !is_div;
    bus.ctrl_DIV      = is_div;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  // Edges counted after the start edge until ready is seen; -1 if it never comes.
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (bus.data_resultRDY) return;
    end
    lat = -1;
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input bit is_div, input logic [31:0] r, input bit e);
    int lat;
    start_op(a, b, is_div);
    wait_rdy(lat);
    check({name, "_lat"}, 32'(lat), 32'(Lat));
    check({name, "_res"}, bus.data_result, r);
    check({name, "_exc"}, 32'(bus.data_exception), 32'(e));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       pick = 32'h0;
      1:       pick = 32'h8000_0000;
      2:       pick = 32'hFFFF_FFFF;
      3:       pick = 32'($urandom_range(1, 20));
      4:       pick = 32'(0 - $urandom_range(1, 20));
      5:       pick = 32'($urandom_range(0, 65535));
      default: pick = $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] mr;
    bit          me;
    int          lat;

    // Pin the model to hand-computed values.
    ref_op(32'd7, 32'hFFFF_FFFA, 1'b0, mr, me);
    check("model_mul", mr, 32'hFFFF_FFD6);
    check("model_mul_exc", 32'(me), 32'd0);
    ref_op(32'h0001_0000, 32'h0001_0000, 1'b0, mr, me);
    check("model_mul_ovf", {mr[31:1], me}, 32'h1);
    ref_op(32'hFFFF_FF9C, 32'd7, 1'b1, mr, me);
    check("model_div", mr, 32'hFFFF_FFF2);
    ref_op(32'd5, 32'd0, 1'b1, mr, me);
    check("model_div0", {mr[31:1], me}, 32'h1);

    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    #1 ctrl_reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_result", bus.data_result, 32'h0);
    check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    ctrl_reset = 1'b1;
    @(negedge clock);

    directed("mul_7x-6", 32'd7, 32'hFFFF_FFFA, 1'b0, 32'hFFFF_FFD6, 1'b0);
    directed("mul_ovf", 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 1'b1);
    directed("mul_m1xmin", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1);
    directed("div_-100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 1'b0);
    directed("div_100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 1'b0);
    directed("div_by0", 32'd5, 32'd0, 1'b1, 32'h0, 1'b1);
    directed("div_min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);

    // Abort: MULT at edge 0, DIV at edge 10.
    start_op(32'd3, 32'd4, 1'b0);
    repeat (9) @(negedge clock);
    check("abort_hold", bus.data_result, 32'h8000_0000);
    directed("abort_div", 32'd100, 32'd10, 1'b1, 32'd10, 1'b0);

    // Reset asserted between edges during a divide.
    start_op(32'd1000, 32'd3, 1'b1);
    repeat (14) @(negedge clock);
    @(posedge clock);
    #2 ctrl_reset = 1'b0;
    #1;
    check("midrst_result", bus.data_result, 32'h0);
    check("midrst_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    wait_rdy(lat);
    check("midrst_no_rdy", 32'(lat), 32'hFFFF_FFFF);

    // Both starts together are ignored.
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd3;
    bus.ctrl_MULT     = 1'b1;
    bus.ctrl_DIV      = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    wait_rdy(lat);
    check("both_no_rdy", 32'(lat), 32'hFFFF_FFFF);

    // Random operations, some aborted at a random point (including the ready edge).
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      bit          d;
      int          rl;
      a = pick();
      b = pick();
      d = 1'($urandom_range(0, 1));
      start_op(a, b, d);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(0, 34)) @(negedge clock);
      end else begin
        wait_rdy(rl);
        check("rand_lat", 32'(rl), 32'(Lat));
      end
    end
    repeat (40) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multicycle signed 32-bit multiply/divide unit in the execute stage.
- Operands come from the register file read ports (regA, regB). The result goes to the writeback path, which writes it into the register file.
- The pipeline stalls on ctrl_MULT/ctrl_DIV and resumes when data_resultRDY pulses.
- Exception output drives the status-register write in writeback.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH; only 32 is supported.

Ports:
clock  input  1  system clock, all state on rising edge
ctrl_reset  input  1  asynchronous, active-low reset (0 = reset)
data_operandA  input  WIDTH  multiplicand / dividend, two's complement
data_operandB  input  WIDTH  multiplier / divisor, two's complement
ctrl_MULT  input  1  start-multiply pulse, sampled on rising edge
ctrl_DIV  input  1  start-divide pulse, sampled on rising edge
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  overflow / divide-by-zero flag for last op
data_resultRDY  output  1  one-cycle pulse: result and exception valid

Behaviour:
- Reset (ctrl_reset=0, asynchronous):
  - State goes to IDLE.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - All internal registers and the counter clear.
  - Effect is immediate, independent of clock.
- States: IDLE, MUL, DIV, FIX.
- Start: at a rising edge with exactly one of ctrl_MULT/ctrl_DIV high (call it edge 0):
  - operands latched;
  - signs recorded, magnitudes formed;
  - counter=0;
  - go to MUL or DIV.
  - Both high: ignored, no state change.
- MUL: radix-2 shift-add on magnitudes; one partial-product step per edge, edges 1..WIDTH. After counter reaches WIDTH-1, go to FIX.
- DIV: restoring division on magnitudes; one quotient bit per edge, edges 1..WIDTH. After counter reaches WIDTH-1, go to FIX.
- FIX: edge WIDTH+1 (edge 33).
  - Sign correction: the product is negated if the operand signs differ. The quotient is negated if the signs differ, truncating toward zero. The remainder is discarded.
  - Exception computed.
  - Then edge WIDTH+2: result registers load, data_resultRDY=1 for exactly that one cycle, state returns to IDLE.
- Latency: start at edge 0, RDY high after edge WIDTH+2 (edge 34), fixed for all operands including divide-by-zero.
- Output hold: data_result/data_exception hold their values after RDY until the next RDY. They do not change during a subsequent operation.
- Multiply exception: the full 2*WIDTH signed product is not equal to the sign extension of its low WIDTH bits. data_result is still the low WIDTH bits.
- Divide exceptions:
  - divisor == 0: data_result=0, data_exception=1.
  - dividend == 0x80000000 and divisor == -1: data_result=0x80000000, data_exception=1.
- Magnitude of 0x80000000: held in a WIDTH+1-bit internal register; no overflow in the datapath.
- Start while busy (MUL/DIV/FIX, or on the RDY edge): the current operation is aborted with no RDY for it. The new operands are latched, the counter is restarted, and latency is measured from the new start edge.
- Reset mid-operation: the operation is abandoned, no RDY. The next start behaves as from power-up.
- data_resultRDY never asserts without a preceding start. It is never high for two consecutive cycles.

Test Plan:
- Reset, then A=7, B=-6 (0xFFFFFFFA), ctrl_MULT pulse -> RDY exactly 34 edges later for one cycle; result 0xFFFFFFD6; exception 0.
- A=0x00010000, B=0x00010000, ctrl_MULT -> result 0x00000000, exception 1. Then A=0xFFFFFFFF, B=0x80000000, MULT -> result 0x80000000, exception 1.
- A=-100 (0xFFFFFF9C), B=7, ctrl_DIV -> result 0xFFFFFFF2 (-14), exception 0. Then A=100, B=-7 -> 0xFFFFFFF2, exception 0.
- A=5, B=0, ctrl_DIV -> result 0, exception 1 at edge 34. Then A=0x80000000, B=0xFFFFFFFF, DIV -> result 0x80000000, exception 1.
- MULT 3*4 started; on edge 10, ctrl_DIV with A=100, B=10 -> no RDY for the MULT; a single RDY 34 edges after the DIV start; result 10; result stays at the old value until then.
- DIV started, ctrl_reset driven low mid-cycle at edge 15 -> outputs go to 0 immediately, with no clock edge needed. Release reset -> no RDY ever appears. Both ctrl_MULT and ctrl_DIV high together -> no RDY.
